phys_free_list: RTL and testbench

- Circular-buffer free list of physical register indices, directly downstream of the retirement RAT.
- Receives each committed instruction's superseded mapping (free_valid/free_pd) and returns it to the pool.
- Supplies the rename stage with one new physical destination per cycle.
- On a commit-time flush, restores the free list in one cycle by making every non-architectural physical register available again.

---
 rtl/phys_free_list.sv | 90 +++++++++
 tb/tb_phys_free_list.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices between the retirement RAT and rename.
// Allocates from a combinational head, reclaims committed mappings, and refills in one cycle on flush.
module phys_free_list #(
    parameter int LOG_REGS = 32,
    parameter int PHY_REGS = 64,
    localparam int DEPTH    = PHY_REGS - LOG_REGS,
    localparam int PRF_BITS = $clog2(PHY_REGS),
    localparam int PTR_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    output logic                alloc_valid,
    output logic [PRF_BITS-1:0] alloc_pd,
    input  logic                free_valid,
    input  logic [PRF_BITS-1:0] free_pd,
    input  logic                flush,
    output logic [PTR_BITS-1:0] count,
    output logic                full,
    output logic                empty,
    output logic                err
);

    localparam int MSB = PTR_BITS - 1;

    // Index bits are the pointer without its wrap bit, so DEPTH must be a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depthCheck
        $fatal(1, "phys_free_list: PHY_REGS - LOG_REGS must be a power of two >= 2");
    end

    logic [PRF_BITS-1:0] r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_rdPtr;
    logic [PTR_BITS-1:0] r_wrPtr;
    logic                r_err;

    logic [PTR_BITS-2:0] w_rdIdx;
    logic [PTR_BITS-2:0] w_wrIdx;
    logic                w_empty;
    logic                w_full;
    logic                w_illegal;
    logic                w_push;
    logic                w_pop;
    logic [PTR_BITS-1:0] w_wrPtrNext;
    logic [PTR_BITS-1:0] w_rdPtrNext;

    always_comb begin
        w_rdIdx     = r_rdPtr[PTR_BITS-2:0];
        w_wrIdx     = r_wrPtr[PTR_BITS-2:0];
        w_empty     = (r_rdPtr == r_wrPtr);
        w_full      = (w_rdIdx == w_wrIdx) && (r_rdPtr[MSB] != r_wrPtr[MSB]);
        w_illegal   = free_valid && (w_full || (free_pd == '0));
        w_push      = free_valid && !w_illegal;
        w_pop       = alloc_req && !w_empty && !flush;
        w_wrPtrNext = r_wrPtr + PTR_BITS'(w_push);
        // Flush parks the read pointer exactly DEPTH behind the post-enqueue write pointer.
        if (flush) begin
            w_rdPtrNext = {~w_wrPtrNext[MSB], w_wrPtrNext[PTR_BITS-2:0]};
        end else begin
            w_rdPtrNext = r_rdPtr + PTR_BITS'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PRF_BITS'(LOG_REGS + i);
            end
            r_rdPtr <= '0;
            r_wrPtr <= {1'b1, {(PTR_BITS-1){1'b0}}};
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[w_wrIdx] <= free_pd;
            end
            r_wrPtr <= w_wrPtrNext;
            r_rdPtr <= w_rdPtrNext;
            if (w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign alloc_valid = !w_empty;
    assign alloc_pd    = r_mem[w_rdIdx];
    assign count       = r_wrPtr - r_rdPtr;
    assign full        = w_full;
    assign empty       = w_empty;
    assign err         = r_err;

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: a history-based reference model predicts each cycle's outputs
// and a separate monitor compares them against the DUT on the falling edge.
module tb_phys_free_list;

    localparam int LOG_REGS = 32;
    localparam int PHY_REGS = 64;
    localparam int DEPTH    = PHY_REGS - LOG_REGS;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_pd;
    logic       free_valid;
    logic [5:0] free_pd;
    logic       flush;
    logic [5:0] count;
    logic       full;
    logic       empty;
    logic       err;

    typedef struct {
        logic       av;
        logic [5:0] pd;
        logic [5:0] cnt;
        logic       full;
        logic       empty;
        logic       err;
    } expT;

    expT expQ[$];

    // Model: the most recent DEPTH registers written into the pool, oldest first.
    // The live free list is always the newest cnt of them; a flush makes all DEPTH live.
    int hist[$];
    int cnt;
    bit mErr;

    int nChecks = 0;
    int nFails  = 0;

    phys_free_list #(.LOG_REGS(LOG_REGS), .PHY_REGS(PHY_REGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_valid(alloc_valid),
        .alloc_pd   (alloc_pd),
        .free_valid (free_valid),
        .free_pd    (free_pd),
        .flush      (flush),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelUpdate(input bit rq, input bit fv, input int pd, input bit fl, input bit rs);
        bit illegal;
        bit push;
        bit pop;
        if (rs) begin
            hist = {};
            for (int i = 0; i < DEPTH; i++) hist.push_back(LOG_REGS + i);
            cnt  = DEPTH;
            mErr = 1'b0;
            return;
        end
        illegal = fv && (cnt == DEPTH || pd == 0);
        push    = fv && !illegal;
        pop     = rq && (cnt > 0) && !fl;
        if (illegal) mErr = 1'b1;
        if (push) begin
            hist.push_back(pd);
            void'(hist.pop_front());
            cnt++;
        end
        if (pop) cnt--;
        if (fl) cnt = DEPTH;
    endtask

    task automatic pushExpected();
        expT e;
        e.av    = (cnt > 0);
        e.pd    = (cnt > 0) ? 6'(hist[DEPTH - cnt]) : 6'd0;
        e.cnt   = 6'(cnt);
        e.full  = (cnt == DEPTH);
        e.empty = (cnt == 0);
        e.err   = mErr;
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge take them, then record the predicted outcome.
    task automatic applyStimulus(input bit rq, input bit fv, input int pd, input bit fl, input bit rs);
        alloc_req  = rq;
        free_valid = fv;
        free_pd    = 6'(pd);
        flush      = fl;
        rst        = rs;
        @(posedge clk);
        #1;
        modelUpdate(rq, fv, pd, fl, rs);
        pushExpected();
    endtask

    // Monitor: compare every pending prediction against the DUT away from the active edge.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            expT e;
            e = expQ.pop_front();
            checkOutput("alloc_valid", int'(alloc_valid), int'(e.av));
            if (e.av) checkOutput("alloc_pd", int'(alloc_pd), int'(e.pd));
            checkOutput("count", int'(count), int'(e.cnt));
            checkOutput("full", int'(full), int'(e.full));
            checkOutput("empty", int'(empty), int'(e.empty));
            checkOutput("err", int'(err), int'(e.err));
        end
    end

    initial begin
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_pd    = '0;
        flush      = 1'b0;
        rst        = 1'b1;
        @(negedge clk);

        // Reset, then eight allocations in a row.
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0);

        // Drain completely, request while empty, then refill with p5.
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 33; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);

        // Concurrent alloc and free, then allocate until p7 comes around after the wrap.
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 7, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) applyStimulus(1, 0, 0, 0, 0);

        // Alloc ten, return two, then flush with a free and an ignored alloc.
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 40, 0, 0);
        applyStimulus(0, 1, 41, 0, 0);
        applyStimulus(1, 1, 9, 1, 0);
        for (int i = 0; i < 33; i++) applyStimulus(1, 0, 0, 0, 0);

        // Overflow and p0 frees both set the sticky error.
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 12, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 3, 0, 0);

        // Reset wins over a concurrent flush, pop and push.
        applyStimulus(1, 1, 22, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Randomized traffic, including occasional flushes, p0 frees and resets.
        for (int i = 0; i < 600; i++) begin
            bit rq;
            bit fv;
            bit fl;
            bit rs;
            int pd;
            rq = ($urandom_range(0, 99) < 60);
            fv = ($urandom_range(0, 99) < 45);
            pd = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 63));
            fl = ($urandom_range(0, 99) < 4);
            rs = ($urandom_range(0, 199) == 0);
            applyStimulus(rq, fv, pd, fl, rs);
        end
        applyStimulus(0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
